// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
// Request fields are held stable by the master while mem_req is high.
interface mem_access_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: load/store over a req/ack data bus with sizing, lane steering and extension.
// Min 3 cycles per access (2 stall cycles), +1 per wait cycle; stall_out holds upstream while a request is open.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALU_Result_in,
  input  logic [31:0] WriteData_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [1:0]  Size_in,
  input  logic        Unsigned_in,
  input  logic [4:0]  rw_in,
  input  logic        MemtoReg_in,
  input  logic        RegWrite_in,
  output logic [31:0] ReadData_out,
  output logic [31:0] ALU_Result_out,
  output logic [4:0]  rw_out,
  output logic        MemtoReg_out,
  output logic        RegWrite_out,
  output logic        stall_out,
  mem_access_stage_if.master bus,
  output logic        err_out,
  output logic [1:0]  err_code
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [29:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        tflag_q, tflag_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;

  logic        access, is_byte, is_half, mis_acc;
  logic [3:0]  req_be;
  logic [31:0] req_wdata, load_ext;

  assign access  = MemRead_in | MemWrite_in;
  assign is_byte = (Size_in == 2'b00);
  assign is_half = (Size_in == 2'b01);
  assign mis_acc = access & ((is_half & ALU_Result_in[0]) |
                             (~is_byte & ~is_half & (ALU_Result_in[1:0] != 2'b00)));

  // Loads always fetch the whole word; the lane is picked on the way back.
  always_comb begin
    req_be    = 4'b1111;
    req_wdata = WriteData_in;
    if (is_byte) begin
      req_wdata = {4{WriteData_in[7:0]}};
      if (MemWrite_in) req_be = 4'b0001 << ALU_Result_in[1:0];
    end else if (is_half) begin
      req_wdata = {2{WriteData_in[15:0]}};
      if (MemWrite_in) req_be = ALU_Result_in[1] ? 4'b1100 : 4'b0011;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    off_d   = off_q;
    size_d  = size_q;
    tflag_d = tflag_q;
    err_d   = 1'b0;
    code_d  = code_q;
    case (state_q)
      IDLE: begin
        if (mis_acc) begin
          err_d  = 1'b1;
          code_d = 2'b01;
        end else if (access) begin
          state_d = REQ;
          cnt_d   = 8'd0;
          req_d   = 1'b1;
          we_d    = MemWrite_in;
          addr_d  = ALU_Result_in[31:2];
          off_d   = ALU_Result_in[1:0];
          size_d  = Size_in;
          be_d    = req_be;
          wdata_d = req_wdata;
        end
      end
      REQ: begin
        if (bus.mem_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          rdata_d = bus.mem_rdata;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d = DONE;
          req_d   = 1'b0;
          rdata_d = 32'd0;
          tflag_d = 1'b1;
          err_d   = 1'b1;
          code_d  = 2'b10;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        tflag_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      off_q   <= '0;
      size_q  <= '0;
      tflag_q <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      off_q   <= off_d;
      size_q  <= size_d;
      tflag_q <= tflag_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  // Extraction uses the offset and size latched when the request went out.
  always_comb begin
    load_ext = rdata_q;
    case (size_q)
      2'b00: begin
        case (off_q)
          2'd0:    load_ext[7:0] = rdata_q[7:0];
          2'd1:    load_ext[7:0] = rdata_q[15:8];
          2'd2:    load_ext[7:0] = rdata_q[23:16];
          default: load_ext[7:0] = rdata_q[31:24];
        endcase
        load_ext[31:8] = {24{~Unsigned_in & load_ext[7]}};
      end
      2'b01: begin
        load_ext[15:0]  = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        load_ext[31:16] = {16{~Unsigned_in & load_ext[15]}};
      end
      default: load_ext = rdata_q;
    endcase
  end

  always_comb begin
    ReadData_out = 32'd0;
    RegWrite_out = 1'b0;
    stall_out    = 1'b0;
    case (state_q)
      IDLE: begin
        stall_out    = access & ~mis_acc;
        RegWrite_out = RegWrite_in & ~mis_acc;
      end
      REQ: begin
        stall_out    = 1'b1;
        RegWrite_out = RegWrite_in;
      end
      DONE: begin
        RegWrite_out = RegWrite_in & ~tflag_q;
        if (!we_q) ReadData_out = load_ext;
      end
      default: ;
    endcase
  end

  assign ALU_Result_out = ALU_Result_in;
  assign rw_out         = rw_in;
  assign MemtoReg_out   = MemtoReg_in;
  assign bus.mem_req    = req_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_be     = be_q;
  assign bus.mem_wdata  = wdata_q;
  assign err_out        = err_q;
  assign err_code       = code_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed cases, random traffic, reset mid-transaction.
module tb_mem_access_stage;
  localparam int TO = 16;
  localparam int NEVER = 1000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ALU_Result_in, WriteData_in;
  logic        MemRead_in, MemWrite_in, Unsigned_in, MemtoReg_in, RegWrite_in;
  logic [1:0]  Size_in;
  logic [4:0]  rw_in;
  logic [31:0] ReadData_out, ALU_Result_out;
  logic [4:0]  rw_out;
  logic        MemtoReg_out, RegWrite_out, stall_out, err_out;
  logic [1:0]  err_code;

  mem_access_stage_if bus();

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .ALU_Result_in(ALU_Result_in), .WriteData_in(WriteData_in),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .Size_in(Size_in), .Unsigned_in(Unsigned_in), .rw_in(rw_in),
    .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in),
    .ReadData_out(ReadData_out), .ALU_Result_out(ALU_Result_out),
    .rw_out(rw_out), .MemtoReg_out(MemtoReg_out), .RegWrite_out(RegWrite_out),
    .stall_out(stall_out), .bus(bus), .err_out(err_out), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          cycles;
  } req_t;

  typedef struct {
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  rw;
    logic        m2r;
    logic        rgw;
    int          stalls;
  } wb_t;

  typedef struct {
    int          delay;
    logic [31:0] rdata;
  } resp_t;

  req_t        reqq[$];
  wb_t         wbq[$];
  resp_t       respq[$];
  logic [1:0]  errq[$];

  int errors = 0;
  int checks = 0;
  logic mon_en = 1'b0;
  logic late_ack = 1'b0;
  logic ack_r = 1'b0;
  logic [31:0] rdata_r = 32'd0;

  assign bus.mem_ack   = ack_r | late_ack;
  assign bus.mem_rdata = late_ack ? 32'hFFFF_FFFF : rdata_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: acknowledges after the delay chosen when the access was issued.
  resp_t cur_resp;
  int    wcnt;
  logic  active = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      active = 1'b0;
      ack_r  = 1'b0;
    end else begin
      if (bus.mem_req && !active) begin
        if (respq.size() == 0) begin
          checks++; errors++;
          $display("FAIL resp_queue: request with no pending response");
          cur_resp.delay = NEVER; cur_resp.rdata = 32'd0;
        end else cur_resp = respq.pop_front();
        active = 1'b1;
        wcnt   = cur_resp.delay;
      end
      if (active && bus.mem_req) begin
        if (wcnt == 0) begin
          ack_r   = 1'b1;
          rdata_r = cur_resp.rdata;
        end else begin
          wcnt--;
          ack_r = 1'b0;
        end
      end else begin
        active = 1'b0;
        ack_r  = 1'b0;
      end
    end
  end

  // Monitor: compares bus requests, error pulses and writeback against the queues.
  req_t cur_req;
  wb_t  cur_wb;
  logic req_seen = 1'b0;
  int   rcnt = 0;
  int   scnt = 0;
  always @(negedge clk) begin
    if (!reset) begin
      req_seen = 1'b0;
      scnt     = 0;
    end else if (mon_en) begin
      if (bus.mem_req) begin
        if (!req_seen) begin
          req_seen = 1'b1;
          rcnt     = 1;
          if (reqq.size() == 0) begin
            checks++; errors++;
            $display("FAIL req_queue: unexpected mem_req addr %h", bus.mem_addr);
            cur_req = '{1'b0, bus.mem_addr, bus.mem_be, bus.mem_wdata, 0};
          end else begin
            cur_req = reqq.pop_front();
            check("mem_we", {31'd0, bus.mem_we}, {31'd0, cur_req.we});
            check("mem_addr", {2'd0, bus.mem_addr}, {2'd0, cur_req.addr});
            check("mem_be", {28'd0, bus.mem_be}, {28'd0, cur_req.be});
            if (cur_req.we) check("mem_wdata", bus.mem_wdata, cur_req.wdata);
          end
        end else begin
          rcnt++;
          check("req_stable_addr", {2'd0, bus.mem_addr}, {2'd0, cur_req.addr});
          check("req_stable_we_be", {27'd0, bus.mem_we, bus.mem_be}, {27'd0, cur_req.we, cur_req.be});
        end
      end else if (req_seen) begin
        check("req_cycles", rcnt, cur_req.cycles);
        req_seen = 1'b0;
      end
      if (err_out) begin
        if (errq.size() == 0) begin
          checks++; errors++;
          $display("FAIL err_queue: unexpected err_out code %b", err_code);
        end else check("err_code", {30'd0, err_code}, {30'd0, errq.pop_front()});
      end
      if (stall_out) scnt++;
      else begin
        if (wbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL wb_queue: unexpected writeback");
        end else begin
          cur_wb = wbq.pop_front();
          check("ReadData_out", ReadData_out, cur_wb.rd);
          check("RegWrite_out", {31'd0, RegWrite_out}, {31'd0, cur_wb.rgw});
          check("ALU_Result_out", ALU_Result_out, cur_wb.alu);
          check("rw_mtr_out", {26'd0, rw_out, MemtoReg_out}, {26'd0, cur_wb.rw, cur_wb.m2r});
          check("stall_cycles", scnt, cur_wb.stalls);
        end
        scnt = 0;
      end
    end
  end

  // Presents one instruction, records what the stage should do, and holds it while stalled.
  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic rd, input logic wr,
                       input logic [1:0] sz, input logic un, input logic [4:0] rwi,
                       input logic m2r, input logic rgw, input int dly, input logic [31:0] rdat);
    int bytes, lane, n;
    logic acc, mis, tout;
    logic [31:0] v;
    req_t r;
    wb_t w;
    resp_t p;
    ALU_Result_in = a; WriteData_in = wd; MemRead_in = rd; MemWrite_in = wr;
    Size_in = sz; Unsigned_in = un; rw_in = rwi; MemtoReg_in = m2r; RegWrite_in = rgw;
    bytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    lane  = int'(a[1:0]);
    acc   = rd | wr;
    mis   = acc && (lane % bytes != 0);
    w.alu = a; w.rw = rwi; w.m2r = m2r; w.rd = 32'd0;
    if (!acc) begin
      w.rgw = rgw; w.stalls = 0;
    end else if (mis) begin
      w.rgw = 1'b0; w.stalls = 0;
      errq.push_back(2'b01);
    end else begin
      tout     = (dly >= TO);
      r.we     = wr;
      r.addr   = a[31:2];
      r.cycles = tout ? TO : dly + 1;
      if (!wr) r.be = 4'hF;
      else if (bytes == 4) r.be = 4'hF;
      else if (bytes == 2) r.be = 4'b0011 << lane;
      else r.be = 4'b0001 << lane;
      if (bytes == 1) r.wdata = {24'd0, wd[7:0]} * 32'h0101_0101;
      else if (bytes == 2) r.wdata = {16'd0, wd[15:0]} * 32'h0001_0001;
      else r.wdata = wd;
      reqq.push_back(r);
      p.delay = dly; p.rdata = rdat;
      respq.push_back(p);
      v = rdat >> (8 * lane);
      if (bytes == 1) begin
        v = v & 32'h0000_00FF;
        if (!un && v[7]) v = v | 32'hFFFF_FF00;
      end else if (bytes == 2) begin
        v = v & 32'h0000_FFFF;
        if (!un && v[15]) v = v | 32'hFFFF_0000;
      end
      w.rd     = (tout || wr) ? 32'd0 : v;
      w.rgw    = rgw & ~tout;
      w.stalls = 1 + r.cycles;
      if (tout) errq.push_back(2'b10);
    end
    wbq.push_back(w);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (!stall_out) break;
      if (n > 400) begin
        checks++; errors++;
        $display("FAIL stall_timeout: stall_out stuck high at %h", a);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_instr();
    issue(32'h0000_1234, 32'd0, 1'b0, 1'b0, 2'b10, 1'b0, 5'd3, 1'b0, 1'b1, 0, 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    int kind, r;
    reset = 1'b0;
    ALU_Result_in = 32'd0; WriteData_in = 32'd0; MemRead_in = 1'b0; MemWrite_in = 1'b0;
    Size_in = 2'b00; Unsigned_in = 1'b0; rw_in = 5'd0; MemtoReg_in = 1'b0; RegWrite_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("rst_mem_addr", {2'd0, bus.mem_addr}, 32'd0);
    check("rst_mem_be", {28'd0, bus.mem_be}, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_err", {29'd0, err_out, err_code}, 32'd0);
    check("rst_stall", {31'd0, stall_out}, 32'd0);
    check("rst_readdata", ReadData_out, 32'd0);
    @(posedge clk); #1;
    reset  = 1'b1;
    mon_en = 1'b1;

    issue(32'h0000_0100, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0, 5'd1, 1'b1, 1'b1, 0, 32'hDEAD_BEEF);
    issue(32'h0000_0103, 32'd0, 1'b1, 1'b0, 2'b00, 1'b0, 5'd2, 1'b1, 1'b1, 1, 32'h8011_2233);
    issue(32'h0000_0103, 32'd0, 1'b1, 1'b0, 2'b00, 1'b1, 5'd2, 1'b1, 1'b1, 0, 32'h8011_2233);
    issue(32'h0000_0202, 32'h0000_ABCD, 1'b0, 1'b1, 2'b01, 1'b0, 5'd0, 1'b0, 1'b0, 3, 32'd0);
    issue(32'h0000_0101, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0, 5'd4, 1'b1, 1'b1, 0, 32'd0);
    issue(32'h0000_0040, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0, 5'd5, 1'b1, 1'b1, NEVER, 32'd0);
    issue(32'h0000_0082, 32'd0, 1'b1, 1'b0, 2'b01, 1'b0, 5'd6, 1'b1, 1'b1, 2, 32'h9876_1234);
    issue(32'h0000_0301, 32'h1122_3344, 1'b1, 1'b1, 2'b00, 1'b0, 5'd7, 1'b0, 1'b1, 0, 32'd0);
    idle_instr();

    for (int i = 0; i < 60; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & 32'hFFFF_FFFC;
      kind = $urandom_range(0, 5);
      r    = $urandom_range(0, 9);
      issue(a, $urandom, (kind == 1 || kind == 2 || kind == 5), (kind >= 3),
            sz, 1'($urandom_range(0, 1)), 5'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), (r == 9) ? NEVER : r % 5, $urandom);
    end
    idle_instr();
    mon_en = 1'b0;
    check("wbq_drained", wbq.size(), 32'd0);
    check("reqq_drained", reqq.size(), 32'd0);
    check("errq_drained", errq.size(), 32'd0);

    // Abandon an open request with reset, then offer a stray ack.
    ALU_Result_in = 32'h0000_0300; MemRead_in = 1'b1; Size_in = 2'b10;
    respq.push_back('{NEVER, 32'd0});
    repeat (4) @(posedge clk);
    #3 reset = 1'b0;
    #1 check("rst_mid_req_drop", {31'd0, bus.mem_req}, 32'd0);
    MemRead_in = 1'b0;
    late_ack = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("late_ack_no_req", {31'd0, bus.mem_req}, 32'd0);
      check("late_ack_no_stall", {31'd0, stall_out}, 32'd0);
      check("late_ack_readdata", ReadData_out, 32'd0);
      check("late_ack_no_err", {31'd0, err_out}, 32'd0);
    end
    late_ack = 1'b0;
    @(posedge clk); #1;
    respq.delete(); wbq.delete(); reqq.delete(); errq.delete();
    mon_en = 1'b1;
    issue(32'h0000_0104, 32'd0, 1'b1, 1'b0, 2'b01, 1'b1, 5'd9, 1'b1, 1'b1, 1, 32'hCAFE_F00D);
    idle_instr();
    mon_en = 1'b0;
    check("post_reset_wbq", wbq.size(), 32'd0);
    check("post_reset_reqq", reqq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Data-memory access stage between the EX/MEM pipeline register and the MEM/WB register.
- Turns load/store control from EX/MEM into a request/acknowledge transaction on an external data-memory bus.
- Handles byte/halfword/word sizing, lane steering and load sign/zero extension.
- Stalls the pipeline while an access is outstanding and flags misaligned or timed-out accesses.

Parameters:
- TIMEOUT, 16, number of REQ-state cycles without mem_ack before a bus error is declared (must be 2..255).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  reset, asynchronous, active-low.
- ALU_Result_in  input  32  effective address / ALU result from EX/MEM.
- WriteData_in  input  32  store data from EX/MEM.
- MemRead_in  input  1  load request.
- MemWrite_in  input  1  store request.
- Size_in  input  2  00 byte, 01 half, 10 word, 11 treated as word.
- Unsigned_in  input  1  1 = zero-extend loads, 0 = sign-extend.
- rw_in  input  5  destination register.
- MemtoReg_in  input  1  writeback select.
- RegWrite_in  input  1  writeback enable.
- ReadData_out  output  32  extended load data to MEM/WB.
- ALU_Result_out  output  32  pass-through of ALU_Result_in.
- rw_out  output  5  pass-through of rw_in.
- MemtoReg_out  output  1  pass-through of MemtoReg_in.
- RegWrite_out  output  1  RegWrite_in, forced 0 on error.
- stall_out  output  1  holds EX/MEM and earlier stages; MEM/WB must capture a bubble while high.
- mem_req  output  1  registered bus request.
- mem_we  output  1  registered, 1 = write.
- mem_addr  output  30  registered word address, ALU_Result_in[31:2].
- mem_be  output  4  registered byte enables, bit i = byte lane i (little-endian).
- mem_wdata  output  32  registered, lane-replicated store data.
- mem_ack  input  1  memory completion, sampled on clk.
- mem_rdata  input  32  read word, valid when mem_ack=1.
- err_out  output  1  one-cycle error pulse.
- err_code  output  2  01 misaligned, 10 bus timeout; held until next error.

Behaviour:
- Reset values:
  - all registered outputs 0; err_code 00; state IDLE; timeout counter 0.
  - Combinational outputs settle to their IDLE values, e.g. stall_out=0 when MemRead_in=MemWrite_in=0.
- Access definitions:
  - access = MemRead_in | MemWrite_in; if both are set, treat as a store.
  - Misaligned = (half and addr[0]) or (word and addr[1:0]!=0).
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - No access: stall_out=0, outputs pass through, ReadData_out=0.
  - Aligned access: stall_out=1; at the next edge register mem_req=1, mem_we, mem_addr, mem_be, mem_wdata; go REQ; clear the counter.
  - Misaligned access: no request, stall_out=0, RegWrite_out=0 this cycle; err_out=1 and err_code=01 at the next edge.
- REQ:
  - stall_out=1; mem_req and all bus fields held stable.
  - mem_ack=1: capture mem_rdata into rdata_q, drop mem_req at the same edge, go DONE.
  - Otherwise increment the counter. When counter==TIMEOUT-1 without ack: drop mem_req, rdata_q=0, set err flag, err_out=1, err_code=10, go DONE.
- DONE:
  - stall_out=0; ReadData_out = extend(rdata_q); RegWrite_out = RegWrite_in & ~timeout_flag.
  - Next edge: go IDLE and clear the flag.
- Latency: minimum 3 cycles in stage (IDLE, REQ with ack, DONE), i.e. 2 stall cycles; each extra wait cycle adds 1.
- Store byte enables:
  - byte: mem_be = 1<<addr[1:0], wdata = {4{WriteData_in[7:0]}}.
  - half: mem_be = addr[1] ? 1100 : 0011, wdata = {2{WriteData_in[15:0]}}.
  - word: mem_be = 1111, wdata = WriteData_in.
- Loads: mem_be = 1111 regardless of size.
- Load extraction: byte lane addr[1:0] or half lane addr[1], then sign/zero-extend to 32 bits per Unsigned_in. Use the address latched at request time.
- Stores: ReadData_out=0 in DONE.
- mem_ack outside REQ is ignored.
- Reset mid-transaction: mem_req drops asynchronously, state returns to IDLE, the transaction is abandoned, and a late ack is ignored.

Test Plan:
- Word load, addr 0x100, ack on first REQ cycle, mem_rdata=0xDEADBEEF -> stall high 2 cycles; DONE shows ReadData_out=0xDEADBEEF, mem_be=1111, mem_addr=0x40.
- Signed byte load, addr 0x103, rdata=0x80112233 -> ReadData_out=0xFFFFFF80; the same with Unsigned_in=1 -> 0x00000080.
- Halfword store, addr 0x202, WriteData_in=0x0000ABCD, ack after 3 wait cycles -> mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1 held stable 4 cycles, 5 stall cycles total.
- Word load at addr 0x101 -> no mem_req, stall_out=0, RegWrite_out=0; err_out pulses 1 cycle, err_code=01.
- Load with ack never asserted, TIMEOUT=16 -> mem_req high exactly 16 cycles; err_code=10; DONE has RegWrite_out=0 and ReadData_out=0.
- reset low during REQ -> mem_req=0 immediately; a late ack after reset causes no capture and no state change.
